// File: rtl/gate_checker_if.sv
// Handshake and stimulus/response bundle between a gate checker and its driver.
// The master drives start/func_sel and feeds back the gate output dut_y.
interface gate_checker_if;
    logic       start;
    logic [1:0] func_sel;
    logic       dut_y;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;

    modport master (
        output start, func_sel, dut_y,
        input  a, b, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        input  start, func_sel, dut_y,
        output a, b, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/gate_checker.sv
// Walks a 2-input gate through its full truth table, waiting SETTLE cycles per
// vector, and reports the mismatch count, the failing vectors and a pass flag.
module gate_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic          clk,
    input  logic          rst,
    gate_checker_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE_ST,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    state_t     state, state_nx;
    logic [1:0] idx;
    logic [1:0] fn;
    logic [3:0] cnt;
    logic       a_q, b_q;
    logic       pass_q;
    logic [2:0] err_q;
    logic [3:0] fail_q;
    logic       expected;
    logic       mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (bus.start) state_nx = APPLY;
            APPLY:     state_nx = (SETTLE == 0) ? SAMPLE : SETTLE_ST;
            SETTLE_ST: if (cnt == SETTLE_LAST) state_nx = SAMPLE;
            SAMPLE:    state_nx = (idx == 2'd3) ? DONE : APPLY;
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state != IDLE);
        bus.done      = (state == DONE);
        bus.a         = a_q;
        bus.b         = b_q;
        bus.pass      = pass_q;
        bus.err_count = err_q;
        bus.fail_vec  = fail_q;
    end

    // Reference value of the latched function for the vector currently driven.
    always_comb begin
        expected = 1'b0;
        case (fn)
            2'b00: expected = a_q & b_q;
            2'b01: expected = a_q | b_q;
            2'b10: expected = a_q ^ b_q;
            2'b11: expected = ~(a_q & b_q);
            default: expected = 1'b0;
        endcase
        mismatch = (bus.dut_y != expected);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            fn     <= '0;
            cnt    <= '0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            pass_q <= 1'b0;
            err_q  <= '0;
            fail_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        fn     <= bus.func_sel;
                        idx    <= '0;
                        err_q  <= '0;
                        fail_q <= '0;
                        pass_q <= 1'b0;
                    end
                end
                APPLY: begin
                    a_q <= idx[0];
                    b_q <= idx[1];
                    cnt <= '0;
                end
                SETTLE_ST: cnt <= cnt + 4'd1;
                SAMPLE: begin
                    if (mismatch) begin
                        if (err_q != 3'd4) err_q <= err_q + 3'd1;
                        fail_q[idx] <= 1'b1;
                    end
                    // pass is resolved here so it is already valid during the done pulse.
                    if (idx == 2'd3) pass_q <= (err_q == 3'd0) && !mismatch;
                    else             idx    <= idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: two instances (SETTLE=2 and SETTLE=0) checked every
// cycle against a timeline model, plus directed scenarios with literal results.
module tb_gate_checker;

    localparam int S_PAR [2] = '{2, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gate_checker_if bus0 ();
    gate_checker_if bus1 ();

    gate_checker #(.SETTLE(2)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    gate_checker #(.SETTLE(0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic       start_r [2];
    logic [1:0] func_r  [2];
    int         gsel    [2];
    logic       noise   [2];

    logic       dy_w   [2];
    logic       a_w    [2];
    logic       b_w    [2];
    logic       busy_w [2];
    logic       done_w [2];
    logic       pass_w [2];
    logic [2:0] err_w  [2];
    logic [3:0] fv_w   [2];

    int checks = 0;
    int errors = 0;
    int done_cnt [2];

    function automatic logic gfun(int g, logic a, logic b);
        case (g)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    assign bus0.start    = start_r[0];
    assign bus1.start    = start_r[1];
    assign bus0.func_sel = func_r[0];
    assign bus1.func_sel = func_r[1];
    assign bus0.dut_y    = gfun(gsel[0], bus0.a, bus0.b) ^ noise[0];
    assign bus1.dut_y    = gfun(gsel[1], bus1.a, bus1.b) ^ noise[1];

    assign dy_w[0] = bus0.dut_y;      assign dy_w[1] = bus1.dut_y;
    assign a_w[0] = bus0.a;           assign a_w[1] = bus1.a;
    assign b_w[0] = bus0.b;           assign b_w[1] = bus1.b;
    assign busy_w[0] = bus0.busy;     assign busy_w[1] = bus1.busy;
    assign done_w[0] = bus0.done;     assign done_w[1] = bus1.done;
    assign pass_w[0] = bus0.pass;     assign pass_w[1] = bus1.pass;
    assign err_w[0] = bus0.err_count; assign err_w[1] = bus1.err_count;
    assign fv_w[0] = bus0.fail_vec;   assign fv_w[1] = bus1.fail_vec;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: after acceptance, edge t of a run with period P=SETTLE+2
    // drives vector t/P when t%P==1 and judges vector t/P-1 when t%P==0.
    logic       m_run [2];
    int         m_t   [2];
    logic [1:0] m_fn  [2];
    logic       m_a   [2];
    logic       m_b   [2];
    int         m_err [2];
    logic [3:0] m_fv  [2];
    logic       m_pass[2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_run[i] <= 1'b0; m_t[i] <= 0; m_fn[i] <= 2'b00;
                m_a[i] <= 1'b0; m_b[i] <= 1'b0; m_err[i] <= 0;
                m_fv[i] <= 4'b0; m_pass[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                automatic int per = S_PAR[i] + 2;
                automatic int len = 4 * per;
                automatic int tn  = m_t[i] + 1;
                automatic int v;
                automatic int ne;
                if (!m_run[i]) begin
                    if (start_r[i]) begin
                        m_run[i] <= 1'b1; m_t[i] <= 0; m_fn[i] <= func_r[i];
                        m_err[i] <= 0; m_fv[i] <= 4'b0; m_pass[i] <= 1'b0;
                    end
                end else if (m_t[i] == len) begin
                    m_run[i] <= 1'b0;
                end else begin
                    m_t[i] <= tn;
                    if (tn % per == 1) begin
                        v = tn / per;
                        m_a[i] <= v[0];
                        m_b[i] <= v[1];
                    end
                    if (tn % per == 0) begin
                        v  = tn / per - 1;
                        ne = m_err[i];
                        if (dy_w[i] != gfun(int'(m_fn[i]), m_a[i], m_b[i])) begin
                            ne = ne + 1;
                            m_fv[i] <= m_fv[i] | (4'b0001 << v);
                        end
                        m_err[i] <= ne;
                        if (tn == len) m_pass[i] <= (ne == 0);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            automatic logic exp_done = m_run[i] && (m_t[i] == 4 * (S_PAR[i] + 2));
            chk($sformatf("busy%0d", i), int'(busy_w[i]), int'(m_run[i]));
            chk($sformatf("done%0d", i), int'(done_w[i]), int'(exp_done));
            chk($sformatf("a%0d", i), int'(a_w[i]), int'(m_a[i]));
            chk($sformatf("b%0d", i), int'(b_w[i]), int'(m_b[i]));
            chk($sformatf("err_count%0d", i), int'(err_w[i]), m_err[i]);
            chk($sformatf("fail_vec%0d", i), int'(fv_w[i]), int'(m_fv[i]));
            chk($sformatf("pass%0d", i), int'(pass_w[i]), int'(m_pass[i]));
            if (done_w[i]) done_cnt[i]++;
        end
    end

    // Launch one run on instance i; n returns edges from acceptance to done.
    task automatic run(input int i, input logic [1:0] f, input int g,
                       input bit hold, output int n);
        gsel[i] = g;
        func_r[i] = f;
        start_r[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start_r[i] = 1'b0;
        func_r[i] = 2'(f + 2'd1);
        n = 0;
        while (!done_w[i] && n < 200) begin
            @(negedge clk);
            n++;
            if (hold) chk("busy_held", int'(busy_w[i]), 1);
        end
        if (hold) begin
            @(posedge clk);
            @(negedge clk);
            start_r[i] = 1'b0;
            chk("busy_after_held", int'(busy_w[i]), 0);
        end
    endtask

    initial begin
        int n;
        int dc;
        for (int i = 0; i < 2; i++) begin
            start_r[i] = 1'b0; func_r[i] = 2'b00; gsel[i] = 0;
            noise[i] = 1'b0; done_cnt[i] = 0;
        end
        #2;
        chk("rst_a", int'(a_w[0]), 0);
        chk("rst_pass", int'(pass_w[0]), 0);
        chk("rst_err", int'(err_w[0]), 0);
        chk("rst_busy", int'(busy_w[0]), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run(0, 2'b00, 0, 1'b0, n);
        chk("and_latency", n, 16);
        chk("and_pass", int'(pass_w[0]), 1);
        chk("and_err", int'(err_w[0]), 0);
        chk("and_fv", int'(fv_w[0]), 0);
        @(negedge clk);
        chk("hold_a", int'(a_w[0]), 1);
        chk("hold_b", int'(b_w[0]), 1);

        run(0, 2'b01, 0, 1'b0, n);
        chk("or_err", int'(err_w[0]), 2);
        chk("or_fv", int'(fv_w[0]), 4'b0110);
        chk("or_pass", int'(pass_w[0]), 0);
        chk("model_or_err", m_err[0], 2);
        @(negedge clk);

        run(0, 2'b11, 0, 1'b0, n);
        chk("nand_err", int'(err_w[0]), 4);
        chk("nand_fv", int'(fv_w[0]), 4'b1111);
        chk("nand_pass", int'(pass_w[0]), 0);
        chk("model_nand_fv", int'(m_fv[0]), 4'b1111);
        @(negedge clk);
        run(0, 2'b11, 3, 1'b0, n);
        chk("nand_ok_pass", int'(pass_w[0]), 1);
        chk("nand_ok_err", int'(err_w[0]), 0);
        @(negedge clk);

        run(1, 2'b10, 2, 1'b0, n);
        chk("xor_s0_latency", n, 8);
        chk("xor_s0_pass", int'(pass_w[1]), 1);
        @(negedge clk);

        // Abort mid-run with an asynchronous reset pulse.
        dc = done_cnt[0];
        gsel[0] = 1;
        func_r[0] = 2'b00;
        start_r[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_r[0] = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy_w[0]), 0);
        chk("abort_a", int'(a_w[0]), 0);
        chk("abort_b", int'(b_w[0]), 0);
        chk("abort_err", int'(err_w[0]), 0);
        chk("abort_fv", int'(fv_w[0]), 0);
        chk("abort_pass", int'(pass_w[0]), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_cnt[0], dc);
        run(0, 2'b00, 0, 1'b0, n);
        chk("post_rst_latency", n, 16);
        chk("post_rst_pass", int'(pass_w[0]), 1);
        @(negedge clk);

        dc = done_cnt[0];
        run(0, 2'b10, 2, 1'b1, n);
        chk("held_latency", n, 16);
        repeat (3) @(negedge clk);
        chk("held_one_done", done_cnt[0], dc + 1);

        // Random start/func_sel/gate/noise traffic, judged by the model alone.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                start_r[i] = ($urandom_range(0, 3) == 0);
                func_r[i] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) gsel[i] = $urandom_range(0, 3);
                noise[i] = ($urandom_range(0, 9) == 0);
            end
        end
        for (int i = 0; i < 2; i++) begin
            start_r[i] = 1'b0;
            noise[i] = 1'b0;
        end
        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
